// File: rtl/wdg_pkg.sv
// wdg_pkg: shared types and constants for the watchdog eigen-pipeline sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wdg_pkg;

  localparam int REGIME_W = 3;

  // Mode word streamed to the output loader when a job faults.
  localparam logic [REGIME_W-1:0] ERR_REGIME = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    RUN,
    LATCH,
    OL_START,
    OL_WAIT,
    FAULT
  } wdg_state_t;

endpackage

// File: rtl/wdg_timeout_cnt.sv
// wdg_timeout_cnt: saturating cycle counter with an expiry flag for the core watchdog.
// Latency: clr/cnt_en take effect on the next clk edge; expired is combinational from the count.
// Backpressure: none; the owner gates cnt_en to freeze the count.
//
// Ports: clk, rst_n (async active-low), clr (synchronous clear, wins over cnt_en),
//        cnt_en (advance by one), expired (count has reached TIMEOUT_CYCLES-1 or beyond).
module wdg_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1023,
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (cnt_en && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // >= rather than == so a count that has already run past the last
  // cycle (ack taken on the final WAIT_ACK cycle) still reads as expired.
  assign expired = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/wdg_seq_ctrl.sv
// wdg_seq_ctrl: sequences param loader -> eig_core -> output_loader with a core timeout watchdog.
// Latency: params_valid -> core_start 1 cycle; core_busy fall -> ol_start 2 cycles; done same cycle as ol_busy fall.
// Backpressure: loader_hold high whenever a job is in flight; ena low freezes everything except err_clr.
//
// Ports: ena (global enable), params_valid/loader_hold (param loader handshake),
//        core_start/core_busy/kappa_in/inv_kappa_in/regime_in (eig_core),
//        ol_start/ol_busy/ol_mode/ol_word_a/ol_word_b (output_loader),
//        err_clr/err_timeout/err_overrun (sticky faults), done (job drained).
// Build option: WDG_RETRY_EN - first timeout of a job restarts the core once before faulting.
module wdg_seq_ctrl
  import wdg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int DATA_W         = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                params_valid,
  output logic                loader_hold,
  output logic                core_start,
  input  logic                core_busy,
  input  logic [DATA_W-1:0]   kappa_in,
  input  logic [DATA_W-1:0]   inv_kappa_in,
  input  logic [REGIME_W-1:0] regime_in,
  output logic                ol_start,
  input  logic                ol_busy,
  output logic [REGIME_W-1:0] ol_mode,
  output logic [DATA_W-1:0]   ol_word_a,
  output logic [DATA_W-1:0]   ol_word_b,
  input  logic                err_clr,
  output logic                err_timeout,
  output logic                err_overrun,
  output logic                done
);

  wdg_state_t state_q, state_d;
  logic       cnt_clr, cnt_en, expired;
  logic       timeout_hit;
  logic       ol_seen_q;   // output loader has gone busy since ol_start
`ifdef WDG_RETRY_EN
  logic       retry_q;     // this job has already used its one restart
`endif

  wdg_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .cnt_en (cnt_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    timeout_hit = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE:     if (params_valid) state_d = START;
        START: begin
          cnt_clr = 1'b1;
          state_d = WAIT_ACK;
        end
        WAIT_ACK: begin
          cnt_en = 1'b1;
          if (core_busy)    state_d = RUN;
          else if (expired) timeout_hit = 1'b1;
        end
        RUN: begin
          // Completion is checked first so a fall on the expiry cycle still latches.
          cnt_en = 1'b1;
          if (!core_busy)   state_d = LATCH;
          else if (expired) timeout_hit = 1'b1;
        end
        LATCH:    state_d = OL_START;
        OL_START: state_d = OL_WAIT;
        OL_WAIT:  if (ol_seen_q && !ol_busy) state_d = IDLE;
        FAULT:    state_d = OL_START;
        default:  state_d = IDLE;
      endcase
      if (timeout_hit) begin
`ifdef WDG_RETRY_EN
        state_d = retry_q ? FAULT : START;
`else
        state_d = FAULT;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ol_seen_q <= 1'b0;
    end else if (ena) begin
      if (state_q == OL_START)                ol_seen_q <= 1'b0;
      else if (state_q == OL_WAIT && ol_busy) ol_seen_q <= 1'b1;
    end
  end

`ifdef WDG_RETRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= 1'b0;
    end else if (ena) begin
      if (state_q == IDLE)  retry_q <= 1'b0;
      else if (timeout_hit) retry_q <= 1'b1;
    end
  end
`endif

  // Result latches: loaded from the core on LATCH, or the error code on FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ol_mode   <= '0;
      ol_word_a <= '0;
      ol_word_b <= '0;
    end else if (ena) begin
      if (state_q == LATCH) begin
        ol_mode   <= regime_in;
        ol_word_a <= kappa_in;
        ol_word_b <= inv_kappa_in;
      end else if (state_q == FAULT) begin
        ol_mode   <= ERR_REGIME;
        ol_word_a <= '0;
        ol_word_b <= '0;
      end
    end
  end

  // Sticky flags: a set event beats a coincident err_clr; err_clr works even with ena low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (ena && state_q == FAULT)                   err_timeout <= 1'b1;
      else if (err_clr)                              err_timeout <= 1'b0;
      if (ena && params_valid && state_q != IDLE)    err_overrun <= 1'b1;
      else if (err_clr)                              err_overrun <= 1'b0;
    end
  end

  assign loader_hold = (state_q != IDLE);
  assign core_start  = ena && (state_q == START);
  assign ol_start    = ena && (state_q == OL_START);
  assign done        = ena && (state_q == OL_WAIT) && ol_seen_q && !ol_busy;

endmodule

// File: tb/tb_wdg_seq_ctrl.sv
// tb_wdg_seq_ctrl: directed table of jobs plus randomized jobs checked against an arithmetic timing model.
// Latency: n/a.
// Backpressure: n/a.
module tb_wdg_seq_ctrl;

  localparam int TO    = 16;
  localparam int DW    = 32;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst_n, ena, params_valid, core_busy, ol_busy, err_clr;
  logic [DW-1:0] kappa_in, inv_kappa_in;
  logic [2:0]    regime_in;
  logic          loader_hold, core_start, ol_start, err_timeout, err_overrun, done;
  logic [2:0]    ol_mode;
  logic [DW-1:0] ol_word_a, ol_word_b;

  always #5 clk = ~clk;

  wdg_seq_ctrl #(.TIMEOUT_CYCLES(TO), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .params_valid(params_valid),
    .loader_hold(loader_hold), .core_start(core_start), .core_busy(core_busy),
    .kappa_in(kappa_in), .inv_kappa_in(inv_kappa_in), .regime_in(regime_in),
    .ol_start(ol_start), .ol_busy(ol_busy), .ol_mode(ol_mode),
    .ol_word_a(ol_word_a), .ol_word_b(ol_word_b), .err_clr(err_clr),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .done(done)
  );

  // One job: all times are job-relative cycles (t=0 is the params_valid cycle),
  // counting only cycles with ena high. Freeze cycles are inserted before t=fz_at.
  typedef struct {
    int          d, l;          // core_busy rises at t=1+d for l cycles (d=NEVER: never)
    int          od, oll;       // ol_busy rises at ols+od for oll cycles
    logic [31:0] k, ik;
    logic [2:0]  rg;
    int          fz_at, fz_len; // ena-low window
    int          ov_at, clr_at, rst_at;
    bit          exp_fault;
    int          exp_ols;       // cycle of ol_start
    int          exp_cs2;       // cycle of a retry core_start (0 = none)
    bit          exp_ovr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int job_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL job%0d %s: got %0h, required %0h", job_id, name, act, req);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Timing model: the core has TO cycles after WAIT_ACK entry to finish; a fall on
  // the last allowed cycle still completes. Fault decision cycle -> FAULT -> OL_START.
  function automatic void predict(input int d, input int l, output bit f,
                                  output int ols, output int cs2);
    int fc;
    cs2 = 0;
    if (d <= TO && d + l <= max2(TO, d + 1)) begin
      f   = 1'b0;
      ols = d + l + 3;
    end else begin
      f  = 1'b1;
      fc = (d > TO) ? 1 + TO : 1 + max2(TO, d + 1);
`ifdef WDG_RETRY_EN
      cs2 = fc + 1;
      fc  = cs2 + TO;
`endif
      ols = fc + 2;
    end
  endfunction

  function automatic vec_t mk(input int d, l, od, oll, input logic [31:0] k, ik,
                              input logic [2:0] rg, input int fz_at, fz_len, ov_at,
                              clr_at, rst_at, input bit f, input int ols, cs2,
                              input bit ovr);
    vec_t v;
    v.d = d; v.l = l; v.od = od; v.oll = oll; v.k = k; v.ik = ik; v.rg = rg;
    v.fz_at = fz_at; v.fz_len = fz_len; v.ov_at = ov_at; v.clr_at = clr_at;
    v.rst_at = rst_at; v.exp_fault = f; v.exp_ols = ols; v.exp_cs2 = cs2; v.exp_ovr = ovr;
    return v;
  endfunction

  task automatic drive_idle();
    ena = 1'b1; params_valid = 1'b0; core_busy = 1'b0; ol_busy = 1'b0; err_clr = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " loader_hold"}, 32'(loader_hold), 0);
    chk({tag, " core_start"},  32'(core_start), 0);
    chk({tag, " ol_start"},    32'(ol_start), 0);
    chk({tag, " done"},        32'(done), 0);
    chk({tag, " ol_mode"},     32'(ol_mode), 0);
    chk({tag, " ol_word_a"},   ol_word_a, 0);
    chk({tag, " ol_word_b"},   ol_word_b, 0);
    chk({tag, " err_timeout"}, 32'(err_timeout), 0);
    chk({tag, " err_overrun"}, 32'(err_overrun), 0);
  endtask

  // err_clr pulse (with random ena, which must not matter) then flags must read 0.
  task automatic idle_clear();
    @(posedge clk); #1;
    ena = 1'($urandom); err_clr = 1'b1;
    @(posedge clk); #1;
    ena = 1'b1; err_clr = 1'b0;
    #4;
    chk("clr err_timeout", 32'(err_timeout), 0);
    chk("clr err_overrun", 32'(err_overrun), 0);
    chk("idle loader_hold", 32'(loader_hold), 0);
  endtask

  task automatic run_job(input vec_t v);
    int dn, t, frz;
    bit aborted;
    dn = v.exp_ols + v.od + v.oll;
    t = 0; frz = 0; aborted = 1'b0;
    while (t <= dn + 1 && !aborted) begin
      @(posedge clk); #1;
      if (v.fz_len > 0 && t == v.fz_at && frz < v.fz_len) begin
        ena = 1'b0; params_valid = 1'b1; err_clr = 1'b0;
        core_busy = 1'($urandom); ol_busy = 1'($urandom);
        kappa_in = $urandom; inv_kappa_in = $urandom; regime_in = 3'($urandom);
        #4;
        chk($sformatf("frz core_start t=%0d", t), 32'(core_start), 0);
        chk($sformatf("frz ol_start t=%0d", t), 32'(ol_start), 0);
        chk($sformatf("frz done t=%0d", t), 32'(done), 0);
        chk($sformatf("frz loader_hold t=%0d", t), 32'(loader_hold), 1);
        frz++;
      end else begin
        ena          = 1'b1;
        params_valid = (t == 0) || (v.ov_at > 0 && t == v.ov_at);
        err_clr      = (v.clr_at > 0 && t == v.clr_at);
        core_busy    = (v.d != NEVER) && (t >= 1 + v.d) && (t < 1 + v.d + v.l);
        ol_busy      = (t >= v.exp_ols + v.od) && (t < dn);
        if (!v.exp_fault && t == v.exp_ols - 1) begin
          kappa_in = v.k; inv_kappa_in = v.ik; regime_in = v.rg;
        end else begin
          kappa_in = $urandom; inv_kappa_in = $urandom; regime_in = 3'($urandom);
        end
        if (v.rst_at > 0 && t == v.rst_at) begin
          #1 rst_n = 1'b0;
          #1 chk_all_zero("rst");
          #2 rst_n = 1'b1;
          aborted = 1'b1;
        end else begin
          #4;
          chk($sformatf("core_start t=%0d", t), 32'(core_start),
              32'(t == 1 || (v.exp_cs2 > 0 && t == v.exp_cs2)));
          chk($sformatf("ol_start t=%0d", t), 32'(ol_start), 32'(t == v.exp_ols));
          chk($sformatf("done t=%0d", t), 32'(done), 32'(t == dn));
          chk($sformatf("loader_hold t=%0d", t), 32'(loader_hold), 32'(t >= 1 && t <= dn));
          t++;
        end
      end
    end
    drive_idle();
    if (!aborted) begin
      chk("ol_mode",     32'(ol_mode),   v.exp_fault ? 32'd7 : 32'(v.rg));
      chk("ol_word_a",   ol_word_a,      v.exp_fault ? 32'd0 : v.k);
      chk("ol_word_b",   ol_word_b,      v.exp_fault ? 32'd0 : v.ik);
      chk("err_timeout", 32'(err_timeout), 32'(v.exp_fault));
      chk("err_overrun", 32'(err_overrun), 32'(v.exp_ovr));
    end
  endtask

  vec_t tbl[13];

  initial begin
    vec_t v;
    bit   f;
    int   ols, cs2, dn;

    // d, l, od, oll, k, ik, rg, fz_at, fz_len, ov_at, clr_at, rst_at, fault, ols, cs2, ovr
    tbl[0]  = mk(3, 10, 2, 4, 32'h0001_8000, 32'h0000_AAAA, 3'd2, 0, 0, 0, 0, 0, 0, 16, 0, 0);
    tbl[1]  = mk(3, 13, 1, 2, 32'h1234_5678, 32'h9ABC_DEF0, 3'd5, 0, 0, 0, 0, 0, 0, 19, 0, 0);
`ifdef WDG_RETRY_EN
    tbl[2]  = mk(3, 14, 1, 2, 32'h1111_1111, 32'h2222_2222, 3'd1, 0, 0, 0, 0, 0, 1, 36, 18, 0);
    tbl[3]  = mk(NEVER, 1, 2, 3, 32'h3333_3333, 32'h4444_4444, 3'd3, 0, 0, 0, 0, 0, 1, 36, 18, 0);
    tbl[5]  = mk(16, 2, 1, 1, 32'h7777_7777, 32'h8888_8888, 3'd6, 0, 0, 0, 0, 0, 1, 37, 19, 0);
`else
    tbl[2]  = mk(3, 14, 1, 2, 32'h1111_1111, 32'h2222_2222, 3'd1, 0, 0, 0, 0, 0, 1, 19, 0, 0);
    tbl[3]  = mk(NEVER, 1, 2, 3, 32'h3333_3333, 32'h4444_4444, 3'd3, 0, 0, 0, 0, 0, 1, 19, 0, 0);
    tbl[5]  = mk(16, 2, 1, 1, 32'h7777_7777, 32'h8888_8888, 3'd6, 0, 0, 0, 0, 0, 1, 20, 0, 0);
`endif
    tbl[4]  = mk(16, 1, 1, 1, 32'h5555_5555, 32'h6666_6666, 3'd4, 0, 0, 0, 0, 0, 0, 20, 0, 0);
    tbl[6]  = mk(1, 1, 1, 1, 32'hFFFF_FFFF, 32'h0000_0001, 3'd0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    tbl[7]  = mk(3, 13, 1, 2, 32'hCAFE_0001, 32'hBEEF_0002, 3'd2, 8, 5, 0, 0, 0, 0, 19, 0, 0);
    tbl[8]  = mk(3, 10, 2, 2, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3'd1, 0, 0, 6, 0, 0, 0, 16, 0, 1);
    tbl[9]  = mk(3, 10, 2, 2, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'd3, 0, 0, 5, 5, 0, 0, 16, 0, 1);
    tbl[10] = mk(3, 10, 2, 2, 32'h0000_00FF, 32'hFF00_0000, 3'd7, 0, 0, 5, 9, 0, 0, 16, 0, 0);
    tbl[11] = mk(3, 10, 3, 5, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3'd2, 0, 0, 5, 0, 18, 0, 16, 0, 1);
    tbl[12] = mk(2, 5, 1, 3, 32'h0001_0002, 32'h0003_0004, 3'd5, 0, 0, 0, 0, 0, 0, 10, 0, 0);

    rst_n = 1'b0; ena = 1'b0; params_valid = 1'b0; core_busy = 1'b0; ol_busy = 1'b0;
    err_clr = 1'b0; kappa_in = '0; inv_kappa_in = '0; regime_in = '0;
    repeat (2) @(posedge clk);
    #5 chk_all_zero("reset");
    rst_n = 1'b1;
    drive_idle();

    for (int i = 0; i < 13; i++) begin
      job_id = i;
      idle_clear();
      run_job(tbl[i]);
    end

    for (int i = 0; i < 40; i++) begin
      job_id = 100 + i;
      do begin
        v.d = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, TO + 3));
        v.l = $urandom_range(1, TO);
        predict(v.d, v.l, f, ols, cs2);
`ifdef WDG_RETRY_EN
      end while (f);
`else
      end while (1'b0);
`endif
      v.exp_fault = f; v.exp_ols = ols; v.exp_cs2 = cs2;
      v.od = $urandom_range(1, 3); v.oll = $urandom_range(1, 4);
      v.k = $urandom; v.ik = $urandom; v.rg = 3'($urandom);
      dn = ols + v.od + v.oll;
      v.fz_len = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      v.fz_at  = $urandom_range(1, ols);
      v.ov_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, dn)) : 0;
      v.exp_ovr = (v.ov_at > 0);
      v.clr_at = 0; v.rst_at = 0;
      idle_clear();
      run_job(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard bound so a wedged run still ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

endmodule
